// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Brief    : Issue/writeback sequencer for an external registered RV32I ALU.
//            Decodes OP/OP-IMM, reads the register file, writes results back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int XLEN      = 32,
  parameter bit REG_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [2:0]      alu_funct3,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic            alu_alt,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [6:0] C_OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] C_OPC_OP    = 7'b0110011;
  localparam logic [6:0] C_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] C_F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_rf [0:31];
  logic [4:0]        r_rd;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_x;
  logic [XLEN-1:0]   r_y;
  logic              r_alt;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic              r_illegal;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic              w_is_op;
  logic              w_is_imm;
  logic              w_f3_alt_ok;
  logic              w_legal;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_imm;

  assign w_opcode    = instr[6:0];
  assign w_f3        = instr[14:12];
  assign w_f7        = instr[31:25];
  assign w_rs1       = instr[19:15];
  assign w_rs2       = instr[24:20];
  assign w_is_op     = (w_opcode == C_OPC_OP);
  assign w_is_imm    = (w_opcode == C_OPC_OPIMM);
  assign w_f3_alt_ok = (w_f3 == 3'b000) || (w_f3 == 3'b101);

  // OP-IMM shifts carry funct7 in the immediate; all other OP-IMM forms take any immediate.
  always_comb begin
    w_legal = 1'b0;
    if (w_is_op) begin
      w_legal = (w_f7 == C_F7_ZERO) || ((w_f7 == C_F7_ALT) && w_f3_alt_ok);
    end else if (w_is_imm) begin
      case (w_f3)
        3'b001:  w_legal = (w_f7 == C_F7_ZERO);
        3'b101:  w_legal = (w_f7 == C_F7_ZERO) || (w_f7 == C_F7_ALT);
        default: w_legal = 1'b1;
      endcase
    end
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
  assign w_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_alt      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_illegal  <= 1'b0;
      if (REG_RESET) begin
        for (int i = 0; i < 32; i++) begin
          r_rf[i] <= '0;
        end
      end
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (w_legal) begin
              r_funct3 <= w_f3;
              r_x      <= w_rs1_val;
              r_y      <= w_is_op ? w_rs2_val : w_imm;
              r_alt    <= w_is_op ? (instr[30] & w_f3_alt_ok) : (instr[30] & (w_f3 == 3'b101));
              r_rd     <= instr[11:7];
              r_state  <= S_EXEC;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_state    <= S_WB;
        end
        S_WB: begin
          if (r_rd != 5'd0) begin
            r_rf[r_rd] <= alu_out;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The ALU result only arrives during WB, so the writeback data is taken straight from it.
  assign wb_data     = r_wb_valid ? alu_out : '0;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign illegal     = r_illegal;
  assign alu_funct3  = r_funct3;
  assign alu_x       = r_x;
  assign alu_y       = r_y;
  assign alu_alt     = r_alt;
  assign instr_ready = (r_state == S_IDLE) && !reset;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : r_rf[dbg_addr];

endmodule

`default_nettype wire
